// File: rtl/rr_sched.sv
// Round-robin dispatcher: pops customer entries from a FIFO and loads them onto
// the next free service counter. Statistics counters are built only with RR_SCHED_STATS_EN.
module rr_sched #(
    parameter int NCNT = 3,
    parameter int TMAX = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            q_empty,
    input  logic [3:0]      q_num,
    input  logic [3:0]      q_tim,
    input  logic [NCNT-1:0] busy,
    output logic            q_re,
    output logic [NCNT-1:0] ld,
    output logic [3:0]      ld_num,
    output logic [3:0]      ld_tim,
    output logic [1:0]      rr_ptr,
    output logic [3:0]      err_cnt,
    output logic [7:0]      served
);

    localparam logic [3:0] TMAX_L = 4'(TMAX);

    typedef enum logic [1:0] {IDLE, POP, CAPT, GRANT} state_t;

    state_t            state_q, state_d;
    logic              q_re_q, q_re_d;
    logic [NCNT-1:0]   ld_q, ld_d;
    logic [3:0]        num_q, num_d;
    logic [3:0]        tim_q, tim_d;
    logic [1:0]        ptr_q, ptr_d;

    logic [1:0]        cand [NCNT];
    logic              found;
    logic [1:0]        pick;
    logic              legal;

    // Candidate order starts at the pointer and wraps modulo the counter count.
    for (genvar gi = 0; gi < NCNT; gi++) begin : g_cand
        logic [2:0] sum;
        assign sum      = {1'b0, ptr_q} + 3'(gi);
        assign cand[gi] = (sum >= 3'(NCNT)) ? 2'(sum - 3'(NCNT)) : sum[1:0];
    end

    always_comb begin
        found = 1'b0;
        pick  = 2'd0;
        for (int i = 0; i < NCNT; i++) begin
            if (!found && !busy[cand[i]]) begin
                found = 1'b1;
                pick  = cand[i];
            end
        end
    end

    assign legal = (q_tim != 4'd0) && (q_tim <= TMAX_L);

    // The grant decision is made one cycle ahead so ld is a registered strobe
    // that is visible during the GRANT cycle itself.
    always_comb begin
        state_d = state_q;
        q_re_d  = 1'b0;
        ld_d    = '0;
        num_d   = num_q;
        tim_d   = tim_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (!hold && !q_empty && busy != '1) begin
                    state_d = POP;
                    q_re_d  = 1'b1;
                end
            end
            POP: state_d = CAPT;
            CAPT: begin
                num_d = q_num;
                tim_d = q_tim;
                if (!legal) begin
                    state_d = IDLE;
                end else begin
                    state_d = GRANT;
                    if (found) begin
                        ld_d[pick] = 1'b1;
                    end
                end
            end
            GRANT: begin
                if (ld_q != '0) begin
                    state_d = IDLE;
                end else if (found) begin
                    ld_d[pick] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (ld_d != '0) begin
            ptr_d = (pick == 2'(NCNT - 1)) ? 2'd0 : pick + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_re_q  <= 1'b0;
            ld_q    <= '0;
            num_q   <= 4'd0;
            tim_q   <= 4'd0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            q_re_q  <= q_re_d;
            ld_q    <= ld_d;
            num_q   <= num_d;
            tim_q   <= tim_d;
            ptr_q   <= ptr_d;
        end
    end

    assign q_re   = q_re_q;
    assign ld     = ld_q;
    assign ld_num = num_q;
    assign ld_tim = tim_q;
    assign rr_ptr = ptr_q;

`ifdef RR_SCHED_STATS_EN
    logic [7:0] served_q;
    logic [3:0] err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            served_q <= 8'd0;
            err_q    <= 4'd0;
        end else begin
            if (ld_d != '0) begin
                served_q <= served_q + 8'd1;
            end
            if (state_q == CAPT && !legal && err_q != 4'hf) begin
                err_q <= err_q + 4'd1;
            end
        end
    end

    assign served  = served_q;
    assign err_cnt = err_q;
`else
    assign served  = 8'd0;
    assign err_cnt = 4'd0;
`endif

endmodule

// File: tb/tb_rr_sched.sv
// Directed bench for rr_sched with a small FIFO model; statistics expectations
// follow RR_SCHED_STATS_EN.
module tb_rr_sched;

`ifdef RR_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk, rst, hold, q_empty;
    logic [3:0] q_num, q_tim;
    logic [2:0] busy;
    logic       q_re;
    logic [2:0] ld;
    logic [3:0] ld_num, ld_tim;
    logic [1:0] rr_ptr;
    logic [3:0] err_cnt;
    logic [7:0] served;

    int errors = 0;
    int checks = 0;

    logic [3:0] fnum [64];
    logic [3:0] ftim [64];
    int head = 0;
    int tail = 0;
    int ld_cnt = 0;
    int qre_cnt = 0;

    rr_sched #(.NCNT(3), .TMAX(7)) dut (
        .clk(clk), .rst(rst), .hold(hold), .q_empty(q_empty),
        .q_num(q_num), .q_tim(q_tim), .busy(busy),
        .q_re(q_re), .ld(ld), .ld_num(ld_num), .ld_tim(ld_tim),
        .rr_ptr(rr_ptr), .err_cnt(err_cnt), .served(served)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign q_empty = (head == tail);

    // FIFO model: data appears the cycle after the read pulse.
    always @(posedge clk) begin
        if (q_re && head != tail) begin
            q_num <= fnum[head % 64];
            q_tim <= ftim[head % 64];
            head  <= head + 1;
        end
    end

    always @(posedge clk) begin
        if (q_re) qre_cnt <= qre_cnt + 1;
        if (ld != 3'b000) begin
            ld_cnt <= ld_cnt + 1;
            $display("load: ld=%b num=%0d tim=%0d rr_ptr=%0d", ld, ld_num, ld_tim, rr_ptr);
            checks++;
            if ($countones(ld) != 1) begin
                errors++;
                $display("FAIL onehot: ld=%b required one-hot", ld);
            end
        end
    end

    task automatic push(input logic [3:0] n, input logic [3:0] t);
        fnum[tail % 64] = n;
        ftim[tail % 64] = t;
        tail = tail + 1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; busy = 3'b000; hold = 1'b0;
        tail = head;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_ld(input int budget, input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (ld == 3'b000 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (ld == 3'b000) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no ld within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        int q0, l0;
        do_reset();
        @(negedge clk);
        checks++; if (q_re !== 1'b0)   begin errors++; $display("FAIL rst_q_re: got %b want 0", q_re); end
        checks++; if (ld !== 3'b000)   begin errors++; $display("FAIL rst_ld: got %b want 000", ld); end
        checks++; if (ld_num !== 4'd0) begin errors++; $display("FAIL rst_ld_num: got %0d want 0", ld_num); end
        checks++; if (ld_tim !== 4'd0) begin errors++; $display("FAIL rst_ld_tim: got %0d want 0", ld_tim); end
        checks++; if (rr_ptr !== 2'd0) begin errors++; $display("FAIL rst_rr_ptr: got %0d want 0", rr_ptr); end
        checks++; if (err_cnt !== 4'd0) begin errors++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
        checks++; if (served !== 8'd0) begin errors++; $display("FAIL rst_served: got %0d want 0", served); end
        q0 = qre_cnt; l0 = ld_cnt;
        repeat (10) @(negedge clk);
        checks++; if (qre_cnt != q0) begin errors++; $display("FAIL idle_q_re: got %0d pulses want 0", qre_cnt - q0); end
        checks++; if (ld_cnt != l0)  begin errors++; $display("FAIL idle_ld: got %0d loads want 0", ld_cnt - l0); end
    endtask

    task automatic test_round_robin();
        int k;
        logic [2:0] exp_ld  [3];
        logic [3:0] exp_num [3];
        logic [3:0] exp_tim [3];
        logic [1:0] exp_ptr [3];
        exp_ld  = '{3'b001, 3'b010, 3'b100};
        exp_num = '{4'd5, 4'd6, 4'd7};
        exp_tim = '{4'd3, 4'd2, 4'd4};
        exp_ptr = '{2'd1, 2'd2, 2'd0};
        do_reset();
        push(5, 3); push(6, 2); push(7, 4);
        k = 0;
        @(negedge clk);
        while (ld == 3'b000 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++; if (k != 3) begin errors++; $display("FAIL latency: got %0d cycles want 3", k); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) wait_ld(12, "rr");
            checks++; if (ld !== exp_ld[i]) begin errors++; $display("FAIL rr_ld%0d: got %b want %b", i, ld, exp_ld[i]); end
            checks++; if (ld_num !== exp_num[i] || ld_tim !== exp_tim[i]) begin
                errors++; $display("FAIL rr_data%0d: got %0d/%0d want %0d/%0d", i, ld_num, ld_tim, exp_num[i], exp_tim[i]);
            end
            @(negedge clk);
            checks++; if (rr_ptr !== exp_ptr[i]) begin errors++; $display("FAIL rr_ptr%0d: got %0d want %0d", i, rr_ptr, exp_ptr[i]); end
        end
        checks++; if (served !== (STATS ? 8'd3 : 8'd0)) begin
            errors++; $display("FAIL served: got %0d want %0d", served, STATS ? 3 : 0);
        end
    endtask

    task automatic test_busy_skip();
        do_reset();
        busy = 3'b011;
        push(9, 5);
        wait_ld(12, "skip");
        checks++; if (ld !== 3'b100 || ld_num !== 4'd9 || ld_tim !== 4'd5) begin
            errors++; $display("FAIL skip_ld: got %b %0d/%0d want 100 9/5", ld, ld_num, ld_tim);
        end
        @(negedge clk);
        checks++; if (rr_ptr !== 2'd0) begin errors++; $display("FAIL skip_ptr: got %0d want 0", rr_ptr); end
        busy = 3'b000;
    endtask

    task automatic test_illegal();
        int q0, l0;
        do_reset();
        q0 = qre_cnt; l0 = ld_cnt;
        push(4, 0); push(4, 8);
        repeat (16) @(negedge clk);
        checks++; if (ld_cnt != l0) begin errors++; $display("FAIL illegal_ld: got %0d loads want 0", ld_cnt - l0); end
        checks++; if (qre_cnt - q0 != 2) begin errors++; $display("FAIL illegal_pops: got %0d want 2", qre_cnt - q0); end
        checks++; if (err_cnt !== (STATS ? 4'd2 : 4'd0)) begin
            errors++; $display("FAIL err_cnt: got %0d want %0d", err_cnt, STATS ? 2 : 0);
        end
        push(1, 7);
        wait_ld(12, "after_illegal");
        checks++; if (ld !== 3'b001 || ld_tim !== 4'd7) begin
            errors++; $display("FAIL after_illegal: got %b tim %0d want 001 tim 7", ld, ld_tim);
        end
    endtask

    task automatic test_all_busy();
        int l0;
        do_reset();
        l0 = ld_cnt;
        push(2, 3);
        @(posedge clk); #1;
        busy = 3'b111;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (ld_cnt != l0) begin errors++; $display("FAIL busy_wait: got %0d loads want 0", ld_cnt - l0); end
        busy = 3'b101;
        wait_ld(6, "busy");
        checks++; if (ld !== 3'b010 || ld_num !== 4'd2 || ld_tim !== 4'd3) begin
            errors++; $display("FAIL busy_ld: got %b %0d/%0d want 010 2/3", ld, ld_num, ld_tim);
        end
        repeat (8) @(negedge clk);
        checks++; if (ld_cnt - l0 != 1) begin errors++; $display("FAIL busy_once: got %0d loads want 1", ld_cnt - l0); end
        busy = 3'b000;
    endtask

    task automatic test_hold();
        int q0;
        do_reset();
        hold = 1'b1;
        q0 = qre_cnt;
        push(11, 6);
        repeat (8) @(negedge clk);
        checks++; if (qre_cnt != q0) begin errors++; $display("FAIL hold_q_re: got %0d pulses want 0", qre_cnt - q0); end
        hold = 1'b0;
        wait_ld(12, "hold");
        checks++; if (ld !== 3'b001 || ld_num !== 4'd11) begin
            errors++; $display("FAIL hold_ld: got %b num %0d want 001 num 11", ld, ld_num);
        end
    endtask

    task automatic test_reset_capt();
        int l0;
        do_reset();
        busy = 3'b000;
        push(8, 1);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        l0 = ld_cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (ld_cnt != l0) begin errors++; $display("FAIL rstcapt_ld: got %0d loads want 0", ld_cnt - l0); end
        checks++; if (rr_ptr !== 2'd0) begin errors++; $display("FAIL rstcapt_ptr: got %0d want 0", rr_ptr); end
        checks++; if (q_empty !== 1'b1) begin errors++; $display("FAIL rstcapt_consumed: q_empty %b want 1", q_empty); end
        push(3, 2);
        wait_ld(12, "rstcapt_next");
        checks++; if (ld !== 3'b001 || ld_num !== 4'd3) begin
            errors++; $display("FAIL rstcapt_next: got %b num %0d want 001 num 3", ld, ld_num);
        end
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; busy = 3'b000;
        test_reset();
        test_round_robin();
        test_busy_skip();
        test_illegal();
        test_all_busy();
        test_hold();
        test_reset_capt();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
